// File: rtl/display_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment scanner.
// seg7_t is active-high {g,f,e,d,c,b,a}. Output polarity is applied only at
// the scanner's output register.
package display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;
  localparam seg7_t SEG_MINUS = 7'h40;  // segment g only

  // Hex glyphs 0-9, A, b, C, d, E, F
  localparam seg7_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment glyph.
// Ports:
//   nibble  in  4   hex digit 0..F
//   seg     out 7   {g..a}, 1 = segment lit
module seg7_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/display_scanner.sv
// N-digit multiplexed 7-segment scanner with dwell prescaler, tear-free
// frame snapshot, PWM brightness, selectable output polarity and a
// frame_done strobe.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bcd          nibble per digit, digit0 = [3:0]
//   dots         decimal point per digit
//   is_negative  show minus on the top digit
//   turn_off     synchronous blank; holds the scan at digit 0
//   brightness   PWM duty, 0 = dimmest, all-ones = full
//   ss_value     {dp,g,f,e,d,c,b,a}
//   ss_select    one-hot digit enable
//   frame_done   1-cycle pulse after each full scan
// Optional build macro: DISPLAY_SCANNER_LZ_BLANK_EN enables leading-zero
// blanking of the upper digits.
module display_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int PRESCALE   = 100000,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] bcd,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic                  is_negative,
  input  logic                  turn_off,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            ss_value,
  output logic [N_DIGITS-1:0]   ss_select,
  output logic                  frame_done
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [7:0] VAL_OFF = {8{POL}};
  localparam logic [N_DIGITS-1:0] SEL_OFF = {N_DIGITS{POL}};

  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
  logic [BRIGHT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [4*N_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [N_DIGITS-1:0]   shadow_dots_q, shadow_dots_d;
  logic                  shadow_neg_q, shadow_neg_d;
  logic [7:0]            ss_value_q, ss_value_d;
  logic [N_DIGITS-1:0]   ss_select_q, ss_select_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0] cur_nib;
  seg7_t      dec_seg;
  seg7_t      glyph;

  // Only the snapshot ever reaches the decoder, so a frame never tears.
  assign cur_nib = shadow_bcd_q[{dig_idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
  logic [N_DIGITS-1:0] lz_blank;

  // Walk from the top digit down; blanking stops at the first nonzero
  // nibble. The minus digit is skipped so the run continues beneath it.
  always_comb begin
    logic leading;
    leading  = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (i == N_DIGITS - 1 && shadow_neg_q) begin
        leading = leading;
      end else if (leading && shadow_bcd_q[4*i +: 4] == 4'h0) begin
        lz_blank[i] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    glyph = dec_seg;
    if (dig_idx_q == IDX_LAST && shadow_neg_q) begin
      glyph = SEG_MINUS;
    end
`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
    else if (lz_blank[dig_idx_q]) begin
      glyph = SEG_BLANK;
    end
`endif
  end

  always_comb begin
    logic tick;
    logic wrap;
    logic capture;
    logic lit;
    logic [7:0] val_raw;
    logic [N_DIGITS-1:0] sel_raw;

    tick    = (pre_cnt_q == PRE_LAST);
    wrap    = tick && (dig_idx_q == IDX_LAST);
    // turn_off overrides a coincident wrap: no capture, no strobe.
    capture = wrap && !turn_off;

    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    dig_idx_d = dig_idx_q;
    if (tick) begin
      dig_idx_d = wrap ? '0 : dig_idx_q + 1'b1;
    end
    if (turn_off) begin
      pre_cnt_d = '0;
      dig_idx_d = '0;
    end

    pwm_cnt_d = pwm_cnt_q + 1'b1;

    shadow_bcd_d  = capture ? bcd         : shadow_bcd_q;
    shadow_dots_d = capture ? dots        : shadow_dots_q;
    shadow_neg_d  = capture ? is_negative : shadow_neg_q;

    lit     = (pwm_cnt_q <= brightness);
    sel_raw = '0;
    if (!turn_off && lit) begin
      sel_raw[dig_idx_q] = 1'b1;
    end
    val_raw = turn_off ? 8'h00 : {shadow_dots_q[dig_idx_q], glyph};

    // Polarity is applied here only; everything upstream is active-high.
    ss_value_d   = val_raw ^ VAL_OFF;
    ss_select_d  = sel_raw ^ SEL_OFF;
    frame_done_d = capture;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      dig_idx_q     <= '0;
      pwm_cnt_q     <= '0;
      shadow_bcd_q  <= '0;
      shadow_dots_q <= '0;
      shadow_neg_q  <= 1'b0;
      ss_value_q    <= VAL_OFF;
      ss_select_q   <= SEL_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      dig_idx_q     <= dig_idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_bcd_q  <= shadow_bcd_d;
      shadow_dots_q <= shadow_dots_d;
      shadow_neg_q  <= shadow_neg_d;
      ss_value_q    <= ss_value_d;
      ss_select_q   <= ss_select_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign ss_value   = ss_value_q;
  assign ss_select  = ss_select_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: N_DIGITS=8, PRESCALE=4, BRIGHT_W=2, ACTIVE_LOW=1.
module tb_display_scanner;

  localparam int N     = 8;
  localparam int P     = 4;
  localparam int BW    = 2;
  localparam int FRAME = N * P;

  // Active-low glyphs for hex 0..F, dp off
  localparam logic [7:0] HEX_AL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   bcd = '0;
  logic [7:0]    dots = '0;
  logic          is_negative = 1'b0;
  logic          turn_off = 1'b0;
  logic [BW-1:0] brightness = 2'd3;
  logic [7:0]    ss_value;
  logic [7:0]    ss_select;
  logic          frame_done;

  always #5 clk = ~clk;

  display_scanner #(
    .N_DIGITS(N), .PRESCALE(P), .BRIGHT_W(BW), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .dots(dots),
    .is_negative(is_negative), .turn_off(turn_off), .brightness(brightness),
    .ss_value(ss_value), .ss_select(ss_select), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Scan position is a single cycle count within the frame; digit and
  // wrap follow from division. Pins are predicted in active-low form.
  int unsigned m_t, m_pwm;
  logic [31:0] m_bcd;
  logic [7:0]  m_dots;
  logic        m_neg;
  logic [16:0] exp_q[$];

  function automatic bit lz_blanked(int d);
`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
    int top;
    top = m_neg ? N - 2 : N - 1;
    if (d == 0 || d > top) return 1'b0;
    for (int j = d; j <= top; j++) if (m_bcd[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  function automatic logic [7:0] model_glyph(int d);
    logic [7:0] v;
    if (d == N - 1 && m_neg) v = 8'hBF;
    else if (lz_blanked(d)) v = 8'hFF;
    else v = HEX_AL[m_bcd[4*d +: 4]];
    if (m_dots[d]) v[7] = 1'b0;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_pwm = 0; m_bcd = '0; m_dots = '0; m_neg = 1'b0;
      exp_q.delete();
      exp_q.push_back({1'b0, 8'hFF, 8'hFF});
    end else begin : model_step
      int d;
      logic [7:0] v, s;
      logic fd;
      d = (m_t / P) % N;
      if (turn_off) begin
        v = 8'hFF; s = 8'hFF;
      end else begin
        v = model_glyph(d);
        s = 8'hFF;
        if (m_pwm <= brightness) s[d] = 1'b0;
      end
      fd = !turn_off && (m_t == FRAME - 1);
      exp_q.push_back({fd, s, v});
      if (fd) begin
        m_bcd = bcd; m_dots = dots; m_neg = is_negative;
      end
      m_t   = turn_off ? 0 : (m_t + 1) % FRAME;
      m_pwm = (m_pwm + 1) % (1 << BW);
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin : sb_check
      logic [16:0] e;
      e = exp_q.pop_front();
      chk("scoreboard", {15'd0, frame_done, ss_select, ss_value}, {15'd0, e});
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_fd(input string name, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) return;
      if (n >= 4 * FRAME) begin
        chk({name, "_timeout"}, 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic wait_sel(input logic [7:0] target);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (ss_select === target) return;
    end
    chk("wait_sel_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0] nib;
    logic [7:0] exp_val;
  } dec_vec_t;

  dec_vec_t vecs [16];

  // ---------------- test sequence ----------------
  initial begin : main
    int n;
    int lit_cnt;
    logic [7:0] lz_exp [N];

    for (int i = 0; i < 16; i++) begin
      vecs[i].nib = 4'(i);
      vecs[i].exp_val = HEX_AL[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_sel", ss_select, 8'hFF);
    chk("reset_val", ss_value, 8'hFF);
    chk("reset_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("frame1_sel", ss_select, 8'hFE);
    chk("frame1_val", ss_value, 8'hC0);

    // Held pattern, frame 2
    bcd = 32'h12345678;
    wait_fd("f1", n);
    @(negedge clk);
    chk("d0_sel", ss_select, 8'hFE);
    chk("d0_val", ss_value, 8'h80);
    repeat (7 * P) @(negedge clk);
    chk("d7_sel", ss_select, 8'h7F);
    chk("d7_val", ss_value, 8'hF9);
    wait_fd("f2", n);
    wait_fd("f3", n);
    chk("fd_period", n, FRAME);

    // Minus and dot
    is_negative = 1'b1;
    dots = 8'h01;
    wait_fd("neg", n);
    @(negedge clk);
    chk("d0_dp", ss_value[7], 1'b0);
    repeat (7 * P) @(negedge clk);
    chk("d7_minus", ss_value, 8'hBF);
    is_negative = 1'b0;
    dots = 8'h00;
    wait_fd("clr", n);

    // Mid-frame change: current frame must stay on the old snapshot
    repeat (10) @(negedge clk);
    bcd = 32'hFFFFFFFF;
    @(negedge clk);
    chk("midframe_hold", ss_value, HEX_AL[6]);
    wait_fd("mid", n);
    @(negedge clk);
    chk("next_frame_F", ss_value, 8'h8E);

    // Brightness 0: one lit cycle in every four
    brightness = 2'd0;
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ss_select !== 8'hFF) lit_cnt++;
    end
    chk("pwm_duty", lit_cnt, 4);
    brightness = 2'd3;

    // turn_off at digit 3
    wait_sel(8'hF7);
    turn_off = 1'b1;
    @(negedge clk);
    chk("off_sel", ss_select, 8'hFF);
    chk("off_val", ss_value, 8'hFF);
    chk("off_fd", frame_done, 1'b0);
    repeat (5) @(negedge clk);
    turn_off = 1'b0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      chk("restart_d0", ss_select, 8'hFE);
    end
    @(negedge clk);
    chk("restart_d1", ss_select, 8'hFD);

    // turn_off coinciding with the wrap tick
    wait_fd("pre_wrap", n);
    repeat (FRAME - 1) @(negedge clk);
    bcd = 32'h00000003;
    turn_off = 1'b1;
    @(negedge clk);
    chk("wrap_off_fd", frame_done, 1'b0);
    turn_off = 1'b0;
    @(negedge clk);
    chk("wrap_off_nocap", ss_value, 8'h8E);

    // Decoder table on digit 0
    for (int k = 0; k < 16; k++) begin
      bcd = {$urandom} & 32'hFFFFFFF0 | {28'd0, vecs[k].nib};
      wait_fd("tbl", n);
      @(negedge clk);
      chk("tbl_sel", ss_select, 8'hFE);
      chk($sformatf("tbl_val_%0h", vecs[k].nib), ss_value, vecs[k].exp_val);
    end

`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
    bcd = 32'h00000042;
    lz_exp = '{8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wait_fd("lz1", n);
    for (int d = 0; d < N; d++) begin
      @(negedge clk);
      chk($sformatf("lz42_d%0d", d), ss_value, lz_exp[d]);
      repeat (P - 1) @(negedge clk);
    end
    bcd = 32'h0;
    lz_exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wait_fd("lz2", n);
    for (int d = 0; d < N; d++) begin
      @(negedge clk);
      chk($sformatf("lz0_d%0d", d), ss_value, lz_exp[d]);
      repeat (P - 1) @(negedge clk);
    end
`else
    lz_exp = '{default: 8'h00};
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) bcd = $urandom;
      if ($urandom_range(0, 15) == 0) dots = 8'($urandom);
      if ($urandom_range(0, 31) == 0) is_negative = ~is_negative;
      if ($urandom_range(0, 31) == 0) brightness = 2'($urandom);
      if (turn_off) turn_off = ($urandom_range(0, 3) != 0);
      else turn_off = ($urandom_range(0, 127) == 0);
      if (it == 700) begin
        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sel", ss_select, 8'hFF);
        chk("async_rst_val", ss_value, 8'hFF);
        chk("async_rst_fd", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
